uart_word_tx: RTL and testbench

- Transmit side of the host UART link: takes a 32-bit word from the core (debug/result readback) and serializes it as 4 UART bytes, MSB byte first.
- Mirrors the receive-side word assembler's byte order, so a host can round-trip instructions and data.
- Contains its own baud-rate divider and 8N1 shift engine.
- Sits between the CPU debug/IO logic and the board TX pin.

---
 rtl/uart_word_tx.sv | 104 ++++++++++
 tb/tb_uart_word_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: serializes a 32-bit word as four back-to-back UART bytes, MSB byte first
//   clk      system clock
//   rst      synchronous reset, active-low
//   word_in  word to transmit, captured on the accept edge
//   send     request, accepted when ready=1
//   ready    idle and able to accept (registered)
//   done     one-cycle pulse as the last stop bit completes (registered)
//   tx       serial line, idle high (registered)
//   UART_WORD_TX_PARITY_EN adds an even-parity bit after each byte's data bits
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        send,
  output logic        ready,
  output logic        done,
  output logic        tx
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
`ifdef UART_WORD_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_d;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [31:0] sh;
  logic [7:0] cur;
  logic bit_end, last_bit, last_byte, accept, tail, tx_d, ready_d, done_d;
  assign cur = sh[31:24];
  assign bit_end = baud_cnt == LAST;
  assign last_bit = bit_idx == 3'd7;
  assign last_byte = byte_idx == 2'd3;
  assign accept = send & ready;
`ifdef UART_WORD_TX_PARITY_EN
  assign tail = ^cur;
`else
  assign tail = 1'b1;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      ready <= 1'b1;
      done <= 1'b0;
    end else begin
      state <= state_d;
      tx <= tx_d;
      ready <= ready_d;
      done <= done_d;
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      bit_idx <= (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
      byte_idx <= (state == STOP && bit_end) ? byte_idx + 2'd1 : byte_idx;
      // the byte on the wire is always sh[31:24]; advance to the next one at each stop-bit end
      sh <= (state == IDLE && accept) ? word_in : (state == STOP && bit_end) ? {sh[23:0], 8'h00} : sh;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = accept ? START : IDLE;
      START: state_d = bit_end ? DATA : START;
      DATA: state_d = (bit_end && last_bit) ? AFTER_DATA : DATA;
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: state_d = bit_end ? STOP : PARITY;
`endif
      STOP: state_d = bit_end ? (last_byte ? IDLE : START) : STOP;
      default: state_d = IDLE;
    endcase
  end
  // tx is registered, so each bit's value is chosen at the edge that ends the previous bit
  always_comb begin
    tx_d = tx;
    ready_d = ready;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        tx_d = accept ? 1'b0 : 1'b1;
        ready_d = !accept;
      end
      START: tx_d = bit_end ? cur[0] : tx;
      DATA: tx_d = bit_end ? (last_bit ? tail : cur[bit_idx + 3'd1]) : tx;
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: tx_d = bit_end ? 1'b1 : tx;
`endif
      STOP: begin
        tx_d = bit_end ? last_byte : tx;
        ready_d = bit_end && last_byte;
        done_d = bit_end && last_byte;
      end
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: randomized self-checking bench against a frame-level bitstream model
module tb_uart_word_tx;
  logic clk = 1'b0, rst = 1'b0, send = 1'b0, send1 = 1'b0;
  logic [31:0] word_in = '0, word1 = '0;
  logic ready, done, tx, ready1, done1, tx1;
  int total = 0, bad = 0;
  bit exp_q[$];
  always #5 clk = ~clk;
  uart_word_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .send(send),
    .ready(ready), .done(done), .tx(tx));
  uart_word_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .word_in(word1), .send(send1),
    .ready(ready1), .done(done1), .tx(tx1));
  function automatic int frame_len();
`ifdef UART_WORD_TX_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction
  function automatic void build(input logic [31:0] w);
    logic [7:0] v;
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      v = 8'(w >> (24 - 8 * b));
      exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_q.push_back(v[j]);
`ifdef UART_WORD_TX_PARITY_EN
      exp_q.push_back(^v);
`endif
      exp_q.push_back(1'b1);
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [31:0] w, input bit fast);
    if (fast) begin word1 = w; send1 = 1'b1; end
    else begin word_in = w; send = 1'b1; end
    tick();
    send = 1'b0;
    send1 = 1'b0;
  endtask
  task automatic check_stream(input logic [31:0] w, input bit fast, input bit churn, input string nm);
    int n;
    logic t, r, d;
    n = fast ? 1 : 4;
    build(w);
    for (int i = 0; i < exp_q.size() * n; i++) begin
      t = fast ? tx1 : tx;
      r = fast ? ready1 : ready;
      d = fast ? done1 : done;
      total++;
      if (t !== exp_q[i / n]) begin
        bad++;
        $display("FAIL %s tx bit %0d cycle %0d: got %b want %b", nm, i / n, i, t, exp_q[i / n]);
      end
      total++;
      if ({r, d} !== 2'b00) begin
        bad++;
        $display("FAIL %s busy flags cycle %0d: ready,done=%b%b want 00", nm, i, r, d);
      end
      if (churn) word_in = $urandom;
      else if (fast) word1 = $urandom;
      else word_in = $urandom;
      tick();
    end
    t = fast ? tx1 : tx;
    r = fast ? ready1 : ready;
    d = fast ? done1 : done;
    total++;
    if ({r, d, t} !== 3'b111) begin
      bad++;
      $display("FAIL %s end of frame: ready,done,tx=%b%b%b want 111", nm, r, d, t);
    end
  endtask
  task automatic finish_frame(input bit fast, input string nm);
    logic t, r, d;
    tick();
    t = fast ? tx1 : tx;
    r = fast ? ready1 : ready;
    d = fast ? done1 : done;
    total++;
    if ({r, d, t} !== 3'b101) begin
      bad++;
      $display("FAIL %s after done: ready,done,tx=%b%b%b want 101", nm, r, d, t);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    send = 1'b1;
    send1 = 1'b1;
    tick();
    tick();
    total++;
    if ({ready, done, tx, ready1, done1, tx1} !== 6'b101101) begin
      bad++;
      $display("FAIL reset: ready,done,tx=%b%b%b fast=%b%b%b want 101101", ready, done, tx, ready1, done1, tx1);
    end
    send = 1'b0;
    send1 = 1'b0;
    rst = 1'b1;
    tick();
  endtask
  task automatic test_words();
    logic [31:0] ws[6];
    ws = '{32'h12345678, 32'hA5000001, 32'h07010300, $urandom, $urandom, $urandom};
    foreach (ws[i]) begin
      start(ws[i], 1'b0);
      check_stream(ws[i], 1'b0, 1'b0, $sformatf("word%0d", i));
      finish_frame(1'b0, $sformatf("word%0d", i));
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    w1 = $urandom;
    w2 = $urandom;
    word_in = w1;
    send = 1'b1;
    tick();
    check_stream(w1, 1'b0, 1'b1, "b2b_first");
    word_in = w2;
    tick();
    check_stream(w2, 1'b0, 1'b1, "b2b_second");
    send = 1'b0;
    finish_frame(1'b0, "b2b_second");
  endtask
  task automatic test_reset_mid();
    int k, pulses;
    k = frame_len() + 1 + 3;
    start($urandom, 1'b0);
    for (int i = 0; i < k * 4 + 1; i++) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({ready, done, tx} !== 3'b101) begin
      bad++;
      $display("FAIL reset_mid: ready,done,tx=%b%b%b want 101", ready, done, tx);
    end
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done || !ready || !tx) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_mid idle: %0d abnormal cycles want 0", pulses);
    end
    start(32'hFFFFFFFF, 1'b0);
    check_stream(32'hFFFFFFFF, 1'b0, 1'b0, "after_reset");
    finish_frame(1'b0, "after_reset");
  endtask
  task automatic test_fast();
    logic [31:0] ws[3];
    ws = '{32'h80000000, $urandom, $urandom};
    foreach (ws[i]) begin
      start(ws[i], 1'b1);
      check_stream(ws[i], 1'b1, 1'b0, $sformatf("fast%0d", i));
      finish_frame(1'b1, $sformatf("fast%0d", i));
    end
  endtask
  initial begin
    test_reset();
    test_words();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
